// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback, long-latency result, register-file write port and
// hazard-lookup signals shared between the pipeline side and the arbiter.
interface wb_port_arbiter_if;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;

   // Pipeline writeback request
   logic              RegWriteW;
   logic [REG_W-1:0]  WriteRegW;
   logic [DATA_W-1:0] ResultW;

   // Long-latency unit result
   logic              LongValid;
   logic [REG_W-1:0]  LongReg;
   logic [DATA_W-1:0] LongData;
   logic              LongReady;

   // Register-file write port
   logic              RegWriteRF;
   logic [REG_W-1:0]  WriteRegRF;
   logic [DATA_W-1:0] WriteDataRF;

   // Hazard-unit lookups and stall request
   logic [REG_W-1:0]  QueryRegA;
   logic [REG_W-1:0]  QueryRegB;
   logic              PendA;
   logic              PendB;
   logic              StallOut;

   // Pipeline / hazard side: drives requests, observes the arbiter
   modport master (
      output RegWriteW, WriteRegW, ResultW,
      output LongValid, LongReg, LongData,
      output QueryRegA, QueryRegB,
      input  LongReady,
      input  RegWriteRF, WriteRegRF, WriteDataRF,
      input  PendA, PendB, StallOut
   );

   // Arbiter side
   modport slave (
      input  RegWriteW, WriteRegW, ResultW,
      input  LongValid, LongReg, LongData,
      input  QueryRegA, QueryRegB,
      output LongReady,
      output RegWriteRF, WriteRegRF, WriteDataRF,
      output PendA, PendB, StallOut
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results wait in a small FIFO and drain into idle writeback slots. Provides
// pending-register lookups and a stall request that prevents FIFO starvation.
module wb_port_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   wb_port_arbiter_if.slave bus
);
   localparam int unsigned REG_W    = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned STARVE_W = 4;

   localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   // FIFO storage (no reset: validity is carried by count and read pointer)
   logic [REG_W-1:0]    r_mem_reg  [DEPTH];
   logic [DATA_W-1:0]   r_mem_data [DEPTH];

   // FIFO control and starvation tracking
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [STARVE_W-1:0] r_starve;

   logic                w_empty;
   logic                w_full;
   logic                w_long_ready;
   logic                w_long_nonzero;
   logic                w_pop;
   logic                w_bypass;
   logic                w_push;
   logic                w_wen;
   logic [REG_W-1:0]    w_wreg;
   logic [DATA_W-1:0]   w_wdata;
   logic [CNT_W-1:0]    w_count_nxt;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic [DEPTH-1:0]    w_entry_valid;
   logic [DEPTH-1:0]    w_hit_a;
   logic [DEPTH-1:0]    w_hit_b;

   assign w_empty        = (r_count == '0);
   assign w_full         = (r_count == FULL_CNT);
   assign w_long_nonzero = (bus.LongReg != '0);

   // Acceptance only looks at registered occupancy, never at a same-cycle pop
   assign w_long_ready = ~reset & ~w_full;

   // Write-port select: pipeline, then FIFO head, then same-cycle bypass
   always_comb begin
      w_wen    = 1'b0;
      w_wreg   = '0;
      w_wdata  = '0;
      w_pop    = 1'b0;
      w_bypass = 1'b0;
      if (!reset) begin
         if (bus.RegWriteW) begin
            w_wen   = 1'b1;
            w_wreg  = bus.WriteRegW;
            w_wdata = bus.ResultW;
         end else if (!w_empty) begin
            w_wen   = 1'b1;
            w_wreg  = r_mem_reg[r_rd_ptr];
            w_wdata = r_mem_data[r_rd_ptr];
            w_pop   = 1'b1;
         end else if (bus.LongValid && w_long_nonzero) begin
            w_wen    = 1'b1;
            w_wreg   = bus.LongReg;
            w_wdata  = bus.LongData;
            w_bypass = 1'b1;
         end
      end
   end

   // Results to $0 are accepted but never stored; bypassed results skip the FIFO
   assign w_push = w_long_ready & bus.LongValid & w_long_nonzero & ~w_bypass;

   // Occupancy next value; simultaneous push and pop cancel
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Starvation counter: counts edges where the pipeline blocks a waiting entry
   always_comb begin
      w_starve_nxt = r_starve;
      if (w_pop || w_empty) begin
         w_starve_nxt = '0;
      end else if (bus.RegWriteW && (r_starve != STARVE_MAX)) begin
         w_starve_nxt = r_starve + STARVE_W'(1);
      end
   end

   // FIFO control state and starvation counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count  <= w_count_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   // FIFO payload write
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_reg[r_wr_ptr]  <= bus.LongReg;
         r_mem_data[r_wr_ptr] <= bus.LongData;
      end
   end

   // Per-entry validity (age from the head below count) and lookup matches;
   // the head being written this cycle still counts as pending
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      logic [PTR_W-1:0] w_age;
      assign w_age            = PTR_W'(g) - r_rd_ptr;
      assign w_entry_valid[g] = (CNT_W'(w_age) < r_count);
      assign w_hit_a[g]       = w_entry_valid[g] & (r_mem_reg[g] == bus.QueryRegA);
      assign w_hit_b[g]       = w_entry_valid[g] & (r_mem_reg[g] == bus.QueryRegB);
   end

   assign bus.PendA = ~reset & (bus.QueryRegA != '0) & (|w_hit_a);
   assign bus.PendB = ~reset & (bus.QueryRegB != '0) & (|w_hit_b);

   // Stall request derived from registered state only
   assign bus.StallOut = ~reset & ((r_starve == STARVE_MAX) | w_full);

   assign bus.LongReady   = w_long_ready;
   assign bus.RegWriteRF  = w_wen;
   assign bus.WriteRegRF  = w_wreg;
   assign bus.WriteDataRF = w_wdata;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (ResultW/WriteRegW from the writeback stage) and a long-latency result source (multiply/divide unit).
- Pipeline writes always win.
- Long-latency results queue in a small FIFO and drain into idle writeback slots.
- Exposes pending-register lookups for the hazard unit, and a stall request so queued results cannot starve.

Parameters:
DEPTH, 2, long-result FIFO entries; power of two, >= 2
STARVE_LIMIT, 4, consecutive starved cycles before StallOut asserts; 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
RegWriteW  input  1  pipeline writeback request
WriteRegW  input  5  pipeline destination register
ResultW  input  32  pipeline writeback data
LongValid  input  1  long-unit result valid
LongReg  input  5  long-unit destination register
LongData  input  32  long-unit result data
LongReady  output  1  arbiter can accept a long result this cycle
RegWriteRF  output  1  register-file write enable
WriteRegRF  output  5  register-file write address
WriteDataRF  output  32  register-file write data
QueryRegA  input  5  hazard-unit lookup (Rs of decode)
QueryRegB  input  5  hazard-unit lookup (Rt of decode)
PendA  output  1  QueryRegA matches a queued, not-yet-written long result
PendB  output  1  QueryRegB matches a queued, not-yet-written long result
StallOut  output  1  request to hazard unit: freeze front end and bubble writeback

Behaviour:
- Reset (async, active-high): FIFO count, read and write pointers, and starve counter clear to 0.
- While reset is high: RegWriteRF=0, LongReady=0, StallOut=0, PendA=PendB=0, WriteRegRF=0, WriteDataRF=0. Outputs are valid from the first clk edge after reset falls.
- Reset mid-operation: queued entries are discarded with no write.
- Write-port select, combinational, same cycle:
  - RegWriteW=1: port carries WriteRegW/ResultW.
  - Else if FIFO non-empty: port carries the FIFO head; head pops at the clock edge.
  - Else if LongValid=1 and LongReg!=0 (bypass): port carries LongReg/LongData; nothing is enqueued.
  - Else RegWriteRF=0.
- LongReady = (count < DEPTH). It does not depend on a same-cycle pop (no full-and-pop enqueue).
- Enqueue happens on LongValid & LongReady, unless the result was bypassed or LongReg==0.
  - LongReg==0 results are accepted and dropped.
  - Push and pop in the same cycle leave count unchanged.
- FIFO ordering is strict first-in first-out. Pointers wrap modulo DEPTH.
- PendX = 1 if QueryRegX != 0 and some valid entry's register equals QueryRegX. Entries count as valid including the head being written this cycle (conservative).
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each edge where count>0 and RegWriteW=1.
  - Clears on any pop or when count==0.
  - StallOut = (starve == STARVE_LIMIT) or (count == DEPTH), from registered state only.
- While StallOut=1, a RegWriteW=1 is still honoured, so correctness never depends on the hazard unit's response latency.
- All widths are exact; no arithmetic on data.

Test Plan:
- Reset then idle: RegWriteRF=0, LongReady=1, StallOut=0. Assert reset mid-queue with count=2 -> count=0, no RF write after release.
- Pipeline only: RegWriteW=1, WriteRegW=8, ResultW=0x1234 -> same cycle RegWriteRF=1, WriteRegRF=8, WriteDataRF=0x1234.
- Bypass: RegWriteW=0, LongValid=1, LongReg=5, LongData=0xAA -> same-cycle RF write of 0xAA to $5; count stays 0.
- Queue and drain: RegWriteW=1 for 3 cycles while LongValid with $9 then $10 -> both queued, PendA=1 for QueryRegA=9, LongReady=0, StallOut=1. Then RegWriteW=0 -> $9 written, next cycle $10 written in order, PendA clears.
- Starvation: one entry queued, RegWriteW=1 continuously -> StallOut rises after 4 edges. The first cycle with RegWriteW=0 drains the entry; StallOut falls the next cycle.
- Register 0: LongValid with LongReg=0 -> accepted, no enqueue, no RF write. QueryRegA=0 -> PendA=0.
